// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Single-domain reset conditioner and staged release sequencer. Resets
//   are asserted asynchronously by rstn. They are released synchronously,
//   one channel at a time in index order, STAGE_DELAY clocks apart. Release
//   only starts once the board reset request has been clean for
//   FILTER_CYCLES clocks and the clock generator reports lock.
//
// Ports
//   clk            domain clock
//   rstn           asynchronous active-low reset
//   reset_req      async active-high external reset request
//   locked         async clock-generator lock indicator
//   sw_reset       synchronous single-cycle software reset request
//   rstn_out       active-low channel resets, driven straight from flops
//   ready          high once every channel has been released
//   lock_loss_cnt  saturating count of lock losses seen outside HOLD

// Plain flop-chain synchroniser with a selectable reset value.
module reset_sequencer_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) chain_q <= {STAGES{RST_VAL}};
        else       chain_q <= chain_d;
    end

    assign q = chain_q[STAGES-1];
endmodule

module reset_sequencer #(
    parameter int NUM_CHANNELS  = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16,
    parameter int STAGE_DELAY   = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    reset_req,
    input  logic                    locked,
    input  logic                    sw_reset,
    output logic [NUM_CHANNELS-1:0] rstn_out,
    output logic                    ready,
    output logic [7:0]              lock_loss_cnt
);
    localparam int FILT_W = $clog2(FILTER_CYCLES + 1);
    localparam int DLY_W  = $clog2(STAGE_DELAY + 1);
    localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic req_sync;
    logic locked_sync;

    // Request syncs to 1 under reset so the filter cannot count until the
    // real input has propagated; lock syncs to 0 so it must be seen first.
    reset_sequencer_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_req_sync (
        .clk (clk),
        .rstn(rstn),
        .d   (reset_req),
        .q   (req_sync)
    );

    reset_sequencer_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_lock_sync (
        .clk (clk),
        .rstn(rstn),
        .d   (locked),
        .q   (locked_sync)
    );

    state_t                  state_q,       state_d;
    logic [FILT_W-1:0]       filt_q,        filt_d;
    logic [DLY_W-1:0]        dly_q,         dly_d;
    logic [IDX_W-1:0]        idx_q,         idx_d;
    logic [NUM_CHANNELS-1:0] rstn_out_q,    rstn_out_d;
    logic                    ready_q,       ready_d;
    logic [7:0]              cnt_q,         cnt_d;
    logic                    locked_prev_q, locked_prev_d;

    logic filt_ok;
    logic lock_fall;
    logic abort;

    always_comb begin
        filt_ok   = (filt_q == FILT_W'(FILTER_CYCLES));
        lock_fall = locked_prev_q & ~locked_sync;
        abort     = (state_q != HOLD) && (req_sync || sw_reset || lock_fall);

        locked_prev_d = locked_sync;
        state_d       = state_q;
        dly_d         = dly_q;
        idx_d         = idx_q;
        rstn_out_d    = rstn_out_q;
        ready_d       = ready_q;
        cnt_d         = cnt_q;

        // Filter runs in every state; only the HOLD exit looks at it.
        filt_d = filt_q;
        if (req_sync || sw_reset) filt_d = '0;
        else if (!filt_ok)        filt_d = filt_q + 1'b1;

        if (lock_fall && (state_q != HOLD) && (cnt_q != 8'hFF))
            cnt_d = cnt_q + 8'd1;

        if (abort) begin
            // Abort outranks a release scheduled on the same edge.
            state_d    = HOLD;
            rstn_out_d = '0;
            ready_d    = 1'b0;
            idx_d      = '0;
            dly_d      = '0;
            filt_d     = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    rstn_out_d = '0;
                    ready_d    = 1'b0;
                    // A request arriving right as the filter saturates
                    // restarts the filter rather than leaking through.
                    if (filt_ok && !req_sync && !sw_reset) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    idx_d = '0;
                    dly_d = '0;
                    if (locked_sync) state_d = RELEASE;
                end
                RELEASE: begin
                    if (dly_q == DLY_W'(STAGE_DELAY - 1)) begin
                        dly_d = '0;
                        idx_d = idx_q + 1'b1;
                        for (int i = 0; i < NUM_CHANNELS; i++)
                            if (idx_q == IDX_W'(i)) rstn_out_d[i] = 1'b1;
                        if (idx_q == IDX_W'(NUM_CHANNELS - 1)) begin
                            ready_d = 1'b1;
                            state_d = RUN;
                        end
                    end else begin
                        dly_d = dly_q + 1'b1;
                    end
                end
                RUN: ;
                default: state_d = HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= HOLD;
            filt_q        <= '0;
            dly_q         <= '0;
            idx_q         <= '0;
            rstn_out_q    <= '0;
            ready_q       <= 1'b0;
            cnt_q         <= '0;
            locked_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            filt_q        <= filt_d;
            dly_q         <= dly_d;
            idx_q         <= idx_d;
            rstn_out_q    <= rstn_out_d;
            ready_q       <= ready_d;
            cnt_q         <= cnt_d;
            locked_prev_q <= locked_prev_d;
        end
    end

    assign rstn_out      = rstn_out_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = cnt_q;
endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;
  typedef struct {
    int         cyc;
    logic [3:0] rst;
    logic       rdy;
    logic [7:0] cnt;
    string      nm;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: defaults. DUT B: 4 channels, STAGE_DELAY=1.
  logic       rstn_a = 1'b0, req_a = 1'b0, locked_a = 1'b1, sw_a = 1'b0;
  logic [1:0] rout_a;
  logic       rdy_a;
  logic [7:0] cnt_a;
  logic       rstn_b = 1'b0, req_b = 1'b0, locked_b = 1'b1, sw_b = 1'b0;
  logic [3:0] rout_b;
  logic       rdy_b;
  logic [7:0] cnt_b;

  reset_sequencer u_dut_a (
    .clk(clk), .rstn(rstn_a), .reset_req(req_a), .locked(locked_a), .sw_reset(sw_a),
    .rstn_out(rout_a), .ready(rdy_a), .lock_loss_cnt(cnt_a)
  );

  reset_sequencer #(.NUM_CHANNELS(4), .STAGE_DELAY(1)) u_dut_b (
    .clk(clk), .rstn(rstn_b), .reset_req(req_b), .locked(locked_b), .sw_reset(sw_b),
    .rstn_out(rout_b), .ready(rdy_b), .lock_loss_cnt(cnt_b)
  );

  exp_t qa[$], qb[$];
  int n_tests = 0, n_fail = 0;
  logic [12:0] prev_a = '0, prev_b = '0;

  task automatic push(input int id, input int c, input logic [3:0] r, input logic rd,
                      input logic [7:0] n, input string nm);
    exp_t e;
    e.cyc = c; e.rst = r; e.rdy = rd; e.cnt = n; e.nm = nm;
    if (id == 0) qa.push_back(e);
    else         qb.push_back(e);
  endtask

  task automatic sb_check(input int id, input logic [3:0] r, input logic rd, input logic [7:0] n);
    exp_t e;
    n_tests++;
    if ((id == 0 && qa.size() == 0) || (id == 1 && qb.size() == 0)) begin
      n_fail++;
      $display("FAIL dut%0d unexpected_change cyc=%0d rstn_out=%b ready=%b cnt=%0d", id, cyc, r, rd, n);
      return;
    end
    if (id == 0) e = qa.pop_front();
    else         e = qb.pop_front();
    if (e.cyc != cyc || e.rst !== r || e.rdy !== rd || e.cnt !== n) begin
      n_fail++;
      $display("FAIL dut%0d %s: got cyc=%0d rstn_out=%b ready=%b cnt=%0d, want cyc=%0d rstn_out=%b ready=%b cnt=%0d",
               id, e.nm, cyc, r, rd, n, e.cyc, e.rst, e.rdy, e.cnt);
    end
  endtask

  // Monitors: every visible output change must match the next expected event.
  always @(negedge clk) begin
    if ({2'b00, rout_a, rdy_a, cnt_a} !== prev_a) begin
      prev_a = {2'b00, rout_a, rdy_a, cnt_a};
      sb_check(0, {2'b00, rout_a}, rdy_a, cnt_a);
    end
  end

  always @(negedge clk) begin
    if ({rout_b, rdy_b, cnt_b} !== prev_b) begin
      prev_b = {rout_b, rdy_b, cnt_b};
      sb_check(1, rout_b, rdy_b, cnt_b);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, c, f, x, l, d;
    tick(3);
    chk("reset_rstn_out_a", 32'(rout_a), 32'h0);
    chk("reset_ready_a",    32'(rdy_a),  32'h0);
    chk("reset_cnt_a",      32'(cnt_a),  32'h0);
    chk("reset_rstn_out_b", 32'(rout_b), 32'h0);

    // 1: clean power-up release
    r = cyc; rstn_a = 1'b1;
    push(0, r + 84,  4'b0001, 1'b0, 8'd0, "t1_ch0");
    push(0, r + 148, 4'b0011, 1'b1, 8'd0, "t1_ch1_ready");
    tick(160);
    chk("t1_cnt", 32'(cnt_a), 32'h0);

    // 3: one-cycle reset_req glitch in RUN
    c = cyc; req_a = 1'b1; tick(1); req_a = 1'b0;
    push(0, c + 3,   4'b0000, 1'b0, 8'd0, "t3_abort");
    push(0, c + 85,  4'b0001, 1'b0, 8'd0, "t3_ch0");
    push(0, c + 149, 4'b0011, 1'b1, 8'd0, "t3_ch1_ready");
    tick(159);

    // 4: request toggling every 10 cycles never lets the filter finish
    c = cyc;
    push(0, c + 3, 4'b0000, 1'b0, 8'd0, "t4_abort");
    for (int k = 0; k < 6; k++) begin
      req_a = 1'b1; tick(10); req_a = 1'b0;
      if (k < 5) tick(10);
    end
    f = cyc;
    push(0, f + 84,  4'b0001, 1'b0, 8'd0, "t4_ch0");
    push(0, f + 148, 4'b0011, 1'b1, 8'd0, "t4_ch1_ready");
    tick(160);

    // 2: unlocked for 500 cycles after rstn
    x = cyc;
    push(0, x, 4'b0000, 1'b0, 8'd0, "t2_rstn_assert");
    rstn_a = 1'b0; locked_a = 1'b0;
    tick(1); rstn_a = 1'b1;
    tick(500);
    l = cyc; locked_a = 1'b1;
    push(0, l + 67, 4'b0001, 1'b0, 8'd0, "t2_ch0");
    tick(80);

    // 5: lock loss mid-RELEASE, repeated until the counter saturates
    d = cyc;
    for (int i = 1; i <= 300; i++) begin
      d = cyc;
      if (i <= 255) push(0, d + 3, 4'b0000, 1'b0, 8'(i), "t5_lock_loss");
      locked_a = 1'b0; tick(5); locked_a = 1'b1; tick(25);
    end
    push(0, d + 85,  4'b0001, 1'b0, 8'd255, "t5_ch0");
    push(0, d + 149, 4'b0011, 1'b1, 8'd255, "t5_ch1_ready");
    tick(130);
    chk("t5_cnt_sat", 32'(cnt_a), 32'd255);

    // 6a: async rstn mid-RELEASE
    x = cyc;
    push(0, x, 4'b0000, 1'b0, 8'd0, "t6_rstn_from_run");
    rstn_a = 1'b0; tick(1);
    r = cyc; rstn_a = 1'b1;
    push(0, r + 84, 4'b0001, 1'b0, 8'd0, "t6_ch0");
    tick(100);
    push(0, r + 100, 4'b0000, 1'b0, 8'd0, "t6_async_assert");
    rstn_a = 1'b0;
    #1;
    chk("t6_async_rstn_out", 32'({rout_a, rdy_a}), 32'h0);
    tick(1);

    // 6b: sw_reset on the edge that would release channel 1
    r = cyc; rstn_a = 1'b1;
    push(0, r + 84, 4'b0001, 1'b0, 8'd0, "t6_sw_ch0");
    tick(147);
    push(0, r + 148, 4'b0000, 1'b0, 8'd0, "t6_sw_wins");
    sw_a = 1'b1; tick(1); sw_a = 1'b0;
    push(0, r + 230, 4'b0001, 1'b0, 8'd0, "t6_sw_rerel_ch0");
    push(0, r + 294, 4'b0011, 1'b1, 8'd0, "t6_sw_rerel_ch1");
    tick(160);

    // 6c: NUM_CHANNELS=4, STAGE_DELAY=1
    r = cyc; rstn_b = 1'b1;
    push(1, r + 21, 4'b0001, 1'b0, 8'd0, "b_ch0");
    push(1, r + 22, 4'b0011, 1'b0, 8'd0, "b_ch1");
    push(1, r + 23, 4'b0111, 1'b0, 8'd0, "b_ch2");
    push(1, r + 24, 4'b1111, 1'b1, 8'd0, "b_ch3_ready");
    tick(30);
    x = cyc;
    push(1, x, 4'b0000, 1'b0, 8'd0, "b_rstn_from_run");
    rstn_b = 1'b0; tick(1);
    r = cyc; rstn_b = 1'b1;
    push(1, r + 21, 4'b0001, 1'b0, 8'd0, "b_async_ch0");
    push(1, r + 22, 4'b0000, 1'b0, 8'd0, "b_async_assert");
    tick(22);
    rstn_b = 1'b0;
    #1;
    chk("b_async_rstn_out", 32'({rout_b, rdy_b}), 32'h0);
    tick(1);
    r = cyc; rstn_b = 1'b1;
    push(1, r + 21, 4'b0001, 1'b0, 8'd0, "b_sw_ch0");
    tick(21);
    push(1, r + 22, 4'b0000, 1'b0, 8'd0, "b_sw_wins");
    sw_b = 1'b1; tick(1); sw_b = 1'b0;
    push(1, r + 41, 4'b0001, 1'b0, 8'd0, "b_rerel_ch0");
    push(1, r + 42, 4'b0011, 1'b0, 8'd0, "b_rerel_ch1");
    push(1, r + 43, 4'b0111, 1'b0, 8'd0, "b_rerel_ch2");
    push(1, r + 44, 4'b1111, 1'b1, 8'd0, "b_rerel_ch3");
    tick(30);

    // sw_reset while still in HOLD only restarts the filter
    x = cyc;
    push(1, x, 4'b0000, 1'b0, 8'd0, "b_rstn_again");
    rstn_b = 1'b0; tick(1);
    r = cyc; rstn_b = 1'b1;
    tick(10);
    push(1, r + 30, 4'b0001, 1'b0, 8'd0, "b_hold_sw_ch0");
    push(1, r + 31, 4'b0011, 1'b0, 8'd0, "b_hold_sw_ch1");
    push(1, r + 32, 4'b0111, 1'b0, 8'd0, "b_hold_sw_ch2");
    push(1, r + 33, 4'b1111, 1'b1, 8'd0, "b_hold_sw_ch3");
    sw_b = 1'b1; tick(1); sw_b = 1'b0;
    tick(40);

    n_tests++;
    if (qa.size() != 0) begin
      n_fail++;
      $display("FAIL dut0 missing_events: %0d pending, next %s", qa.size(), qa[0].nm);
    end
    n_tests++;
    if (qb.size() != 0) begin
      n_fail++;
      $display("FAIL dut1 missing_events: %0d pending, next %s", qb.size(), qb[0].nm);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
